// File: rtl/uart_tx_arbiter.sv
// Round-robin line-locking arbiter feeding bytes from NREQ requesters into a UART TX buffer.
// Tracks buffer occupancy (0x0A costs two slots) and releases the lock on newline or owner timeout.
module uart_tx_arbiter #(
  parameter int NREQ    = 4,
  parameter int DEPTH   = 256,
  parameter int TIMEOUT = 1024
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [8*NREQ-1:0]        req_char,
  output logic [NREQ-1:0]          req_ready,
  output logic [7:0]               buf_char,
  output logic                     buf_char_valid,
  input  logic                     buf_send,
  output logic [$clog2(NREQ)-1:0]  owner,
  output logic                     locked,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic                     err_underflow
);

  localparam int OW  = $clog2(NREQ);
  localparam int OCW = $clog2(DEPTH) + 1;
  localparam int CW  = $clog2(TIMEOUT + 1);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t          state_q, state_d;
  logic [OW-1:0]   owner_q, owner_d;
  logic [OW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [OCW-1:0]  occ_q, occ_d;
  logic [CW-1:0]   idle_q, idle_d;
  logic            err_q, err_d;
  logic [7:0]      char_q, char_d;
  logic            valid_q, valid_d;

  logic [7:0]      req_byte [NREQ];
  logic            grant_found;
  logic [OW-1:0]   grant_idx;
  logic [OW-1:0]   cand;
  logic            owner_valid;
  logic [7:0]      owner_byte;
  logic            can_accept;
  logic            xfer;
  logic            release_lock;
  logic [1:0]      inc;
  logic            dec;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_bytes
    assign req_byte[gi] = req_char[8*gi +: 8];
  end

  assign owner_valid = req_valid[owner_q];
  assign owner_byte  = req_byte[owner_q];
  // Two free slots are kept so a newline can always expand to CR+LF.
  assign can_accept  = (int'(occ_q) + 2) <= (DEPTH - 1);

  // Scan downwards so the candidate nearest after rr_ptr is the last one kept.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = NREQ; k >= 1; k--) begin
      cand = OW'((int'(rr_ptr_q) + k) % NREQ);
      if (req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    rr_ptr_d     = rr_ptr_q;
    idle_d       = idle_q;
    char_d       = char_q;
    valid_d      = 1'b0;
    req_ready    = '0;
    xfer         = 1'b0;
    release_lock = 1'b0;
    inc          = 2'd0;

    case (state_q)
      IDLE: begin
        idle_d = '0;
        if (grant_found) begin
          owner_d = grant_idx;
          state_d = LOCKED;
        end
      end
      LOCKED: begin
        req_ready[owner_q] = can_accept;
        xfer = owner_valid & can_accept;
        if (xfer) begin
          char_d  = owner_byte;
          valid_d = 1'b1;
          inc     = (owner_byte == 8'h0A) ? 2'd2 : 2'd1;
        end
        idle_d = owner_valid ? '0 : idle_q + CW'(1);
        release_lock = (xfer && owner_byte == 8'h0A) ||
                       (!owner_valid && idle_q == CW'(TIMEOUT - 1));
        if (release_lock) begin
          state_d  = IDLE;
          rr_ptr_d = owner_q;
          idle_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase

    dec   = buf_send && (occ_q != '0);
    err_d = err_q | (buf_send && (occ_q == '0));
    occ_d = occ_q + OCW'(inc) - OCW'(dec);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      owner_q  <= '0;
      rr_ptr_q <= OW'(NREQ - 1);
      occ_q    <= '0;
      idle_q   <= '0;
      err_q    <= 1'b0;
      char_q   <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      occ_q    <= occ_d;
      idle_q   <= idle_d;
      err_q    <= err_d;
      char_q   <= char_d;
      valid_q  <= valid_d;
    end
  end

  assign buf_char       = char_q;
  assign buf_char_valid = valid_q;
  assign owner          = owner_q;
  assign locked         = (state_q == LOCKED);
  assign occupancy      = occ_q;
  assign err_underflow  = err_q;

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 4, meaning number of byte requesters (2..8).
REQ-002 SHALL have parameter DEPTH, default 256, meaning slot count of the downstream UART buffer (usable capacity DEPTH-1).
REQ-003 SHALL have parameter TIMEOUT, default 1024, meaning owner-idle cycles before forced lock release.
REQ-004 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port req_valid  input  NREQ  per-requester byte-valid.
REQ-007 SHALL have port req_char  input  8*NREQ  per-requester byte, requester i at bits [8i+7:8i].
REQ-008 SHALL have port req_ready  output  NREQ  per-requester accept; at most one bit high.
REQ-009 SHALL have port buf_char  output  8  byte to the UART buffer.
REQ-010 SHALL have port buf_char_valid  output  1  one-cycle write strobe to the UART buffer.
REQ-011 SHALL have port buf_send  input  1  one-cycle pulse per byte drained from the UART buffer.
REQ-012 SHALL have port owner  output  clog2(NREQ)  index of current lock owner.
REQ-013 SHALL have port locked  output  1  high while a requester holds the line lock.
REQ-014 SHALL have port occupancy  output  clog2(DEPTH)+1  bytes currently held in the UART buffer.
REQ-015 SHALL have port err_underflow  output  1  sticky flag: buf_send seen at occupancy 0.

Function
REQ-016 SHALL implement two states, IDLE and LOCKED.
REQ-017 In IDLE, SHALL assert no req_ready bit.
REQ-018 In IDLE with any req_valid high, SHALL pick the first valid index strictly after rr_ptr (modulo NREQ), load owner, and enter LOCKED next cycle.
REQ-019 In LOCKED, SHALL drive req_ready[owner]=1 iff occupancy+2 <= DEPTH-1 (newline expansion reserve); all other bits 0.
REQ-020 A transfer SHALL occur when req_valid[owner] & req_ready[owner]; the next cycle buf_char=byte and buf_char_valid=1, else buf_char_valid=0 and buf_char holds.
REQ-021 Occupancy SHALL add 2 for transferred byte 0x0A (buffer appends 0x0D), 1 otherwise, and subtract 1 per buf_send; simultaneous events SHALL net in the same cycle.
REQ-022 buf_send at occupancy 0 SHALL leave occupancy 0 and set err_underflow (cleared only by reset).
REQ-023 Transfer of 0x0A by owner SHALL release the lock: next cycle IDLE, rr_ptr=owner.
REQ-024 An idle counter SHALL count LOCKED cycles with req_valid[owner]=0, clear on any owner valid; on reaching TIMEOUT SHALL release as in REQ-023.
REQ-025 Non-owner req_valid SHALL never affect the lock; arbitration happens only in IDLE.
REQ-026 After a release, the IDLE cycle SHALL arbitrate immediately (minimum one IDLE cycle between locks).
REQ-027 With occupancy at DEPTH-2 or higher, owner SHALL stall with req_ready=0 without losing lock or incrementing idle counter.

Reset
REQ-028 On rst assertion, asynchronously: state IDLE, req_ready=0, buf_char_valid=0, buf_char=0x00, owner=0, locked=0, occupancy=0, idle counter=0, err_underflow=0, rr_ptr=NREQ-1 (requester 0 wins first).
REQ-029 Reset mid-transfer SHALL drop any pending strobe; no byte output until a new lock is granted after deassertion.

Verification
REQ-030 Reset, req_valid=4'b0110 -> owner=1, locked=1 two cycles later; req0 and req2 see req_ready=0.
REQ-031 Owner 1 sends "A","B",0x0A -> buf_char_valid pulses with 0x41,0x42,0x0A; occupancy=4; lock released, next grant goes to requester 2.
REQ-032 DEPTH=8, no buf_send, owner streams 0x41 -> req_ready drops when occupancy=6; one buf_send -> req_ready=1 next cycle.
REQ-033 Owner lowers req_valid for TIMEOUT=16 cycles -> locked=0 at cycle 16; a competing requester granted after one IDLE cycle.
REQ-034 Same cycle transfer 0x0A and buf_send at occupancy 3 -> occupancy 4.
REQ-035 buf_send at occupancy 0 -> occupancy stays 0, err_underflow=1 until rst.
